// File: rtl/vga_timing.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : vga_timing                                                    |
// | Description : 640x480@60 Hz raster timing generator on the 25 MHz pixel     |
// |               clock. Full-frame X/Y counters, DAC sync/blank strobes and    |
// |               per-line / per-frame pulses for the renderer and game logic.  |
// |               Optional macro VGA_TIMING_PIPE_EN delays HS/VS/BLANK_N by one |
// |               cycle to line up with a registered RGB path.                  |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module vga_timing #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10
) (
  input  logic       VGA_CLK,
  input  logic       reset,
  output logic [9:0] VGA_X,
  output logic [9:0] VGA_Y,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       active,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam logic [9:0] C_H_TOT    = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP);
  localparam logic [9:0] C_V_TOT    = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP);
  localparam logic [9:0] C_H_SYNC   = 10'(H_SYNC);
  localparam logic [9:0] C_V_SYNC   = 10'(V_SYNC);
  localparam logic [9:0] C_H_ACT_LO = 10'(H_SYNC + H_BP);
  localparam logic [9:0] C_H_ACT_HI = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] C_V_ACT_LO = 10'(V_SYNC + V_BP);
  localparam logic [9:0] C_V_ACT_HI = 10'(V_SYNC + V_BP + V_ACTIVE);

  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;
  logic       w_x_wrap;
  logic       w_frame_wrap;
  logic       w_hs_nxt;
  logic       w_vs_nxt;
  logic       w_act_nxt;
  logic       r_hs;
  logic       r_vs;
  logic       r_act;

  // Next counter values and the strobes they imply; decoding the next value
  // lets the registered strobes line up exactly with the registered counters.
  always_comb begin
    w_x_wrap     = (VGA_X == C_H_TOT - 10'd1);
    w_frame_wrap = w_x_wrap && (VGA_Y == C_V_TOT - 10'd1);
    w_x_nxt      = w_x_wrap ? 10'd0 : VGA_X + 10'd1;
    w_y_nxt      = VGA_Y;
    if (w_frame_wrap) begin
      w_y_nxt = 10'd0;
    end else if (w_x_wrap) begin
      w_y_nxt = VGA_Y + 10'd1;
    end
    w_hs_nxt  = (w_x_nxt >= C_H_SYNC);
    w_vs_nxt  = (w_y_nxt >= C_V_SYNC);
    w_act_nxt = (w_x_nxt >= C_H_ACT_LO) && (w_x_nxt < C_H_ACT_HI) &&
                (w_y_nxt >= C_V_ACT_LO) && (w_y_nxt < C_V_ACT_HI);
  end

  // Raster counters, zero-skew strobes, pulses and the frame counter.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      VGA_X       <= 10'd0;
      VGA_Y       <= 10'd0;
      r_hs        <= 1'b0;
      r_vs        <= 1'b0;
      r_act       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      VGA_X       <= w_x_nxt;
      VGA_Y       <= w_y_nxt;
      r_hs        <= w_hs_nxt;
      r_vs        <= w_vs_nxt;
      r_act       <= w_act_nxt;
      line_start  <= (w_x_nxt == 10'd0);
      frame_start <= (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0);
      if (w_frame_wrap) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

`ifdef VGA_TIMING_PIPE_EN
  logic r_hs_d;
  logic r_vs_d;
  logic r_blank_n_d;

  // Extra stage so the DAC strobes match the renderer's registered RGB.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      r_hs_d      <= 1'b0;
      r_vs_d      <= 1'b0;
      r_blank_n_d <= 1'b0;
    end else begin
      r_hs_d      <= r_hs;
      r_vs_d      <= r_vs;
      r_blank_n_d <= r_act;
    end
  end

  assign VGA_HS      = r_hs_d;
  assign VGA_VS      = r_vs_d;
  assign VGA_BLANK_N = r_blank_n_d;
`else
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_act;
`endif

  // Game logic always sees the undelayed decode; no sync-on-green.
  assign active     = r_act;
  assign VGA_SYNC_N = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_vga_timing                                                 |
// | Description : Self-checking bench for vga_timing. A full-size instance      |
// |               covers the first 36 lines of real 640x480 timing; a small-    |
// |               raster instance covers whole frames, 256-frame wrap and       |
// |               mid-frame reset within a short run.                           |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_vga_timing;

  localparam int FHS = 96, FHB = 48, FHA = 640, FHF = 16;
  localparam int FVS = 2,  FVB = 33, FVA = 480, FVF = 10;
  localparam int SHS = 4,  SHB = 3,  SHA = 8,   SHF = 2;
  localparam int SVS = 2,  SVB = 3,  SVA = 5,   SVF = 2;
  localparam int SHT = SHS + SHB + SHA + SHF;
  localparam int SFR = SHT * (SVS + SVB + SVA + SVF);
`ifdef VGA_TIMING_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  typedef struct {
    int x; int y; int fc;
    bit hs; bit vs; bit act; bit ls; bit fs;
  } ref_t;

  logic VGA_CLK = 1'b0;
  always #20 VGA_CLK = ~VGA_CLK;

  logic       f_reset, s_reset;
  logic [9:0] f_x, f_y, s_x, s_y;
  logic       f_hs, f_vs, f_bn, f_sn, f_act, f_ls, f_fs;
  logic       s_hs, s_vs, s_bn, s_sn, s_act, s_ls, s_fs;
  logic [7:0] f_fc, s_fc;

  int errors = 0;
  int checks = 0;
  int s_n    = 0;

  vga_timing dut_full (
    .VGA_CLK(VGA_CLK), .reset(f_reset), .VGA_X(f_x), .VGA_Y(f_y),
    .VGA_HS(f_hs), .VGA_VS(f_vs), .VGA_BLANK_N(f_bn), .VGA_SYNC_N(f_sn),
    .active(f_act), .line_start(f_ls), .frame_start(f_fs), .frame_count(f_fc)
  );

  vga_timing #(
    .H_SYNC(SHS), .H_BP(SHB), .H_ACTIVE(SHA), .H_FP(SHF),
    .V_SYNC(SVS), .V_BP(SVB), .V_ACTIVE(SVA), .V_FP(SVF)
  ) dut_small (
    .VGA_CLK(VGA_CLK), .reset(s_reset), .VGA_X(s_x), .VGA_Y(s_y),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_bn), .VGA_SYNC_N(s_sn),
    .active(s_act), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  // Reference: state n cycles after reset release, from the raster rules.
  function automatic ref_t ref_at(int n, int hs, int hb, int ha, int hf,
                                  int vs, int vb, int va, int vf);
    ref_t r;
    int ht = hs + hb + ha + hf;
    int vt = vs + vb + va + vf;
    r.x   = n % ht;
    r.y   = (n / ht) % vt;
    r.fc  = (n / (ht * vt)) % 256;
    r.hs  = (r.x >= hs);
    r.vs  = (r.y >= vs);
    r.act = (r.x >= hs + hb) && (r.x < hs + hb + ha) &&
            (r.y >= vs + vb) && (r.y < vs + vb + va);
    r.ls  = (r.x == 0);
    r.fs  = (r.x == 0) && (r.y == 0);
    return r;
  endfunction

  function automatic ref_t ref_full(int n);
    return ref_at(n, FHS, FHB, FHA, FHF, FVS, FVB, FVA, FVF);
  endfunction

  function automatic ref_t ref_small(int n);
    return ref_at(n, SHS, SHB, SHA, SHF, SVS, SVB, SVA, SVF);
  endfunction

  task automatic test_reset();
    f_reset = 1'b1;
    s_reset = 1'b1;
    repeat (3) begin
      @(posedge VGA_CLK); #1;
      checks += 10;
      if (f_x !== 10'd0)  begin errors++; $display("FAIL reset_x got=%0d exp=0", f_x); end
      if (f_y !== 10'd0)  begin errors++; $display("FAIL reset_y got=%0d exp=0", f_y); end
      if (f_hs !== 1'b0)  begin errors++; $display("FAIL reset_hs got=%b exp=0", f_hs); end
      if (f_vs !== 1'b0)  begin errors++; $display("FAIL reset_vs got=%b exp=0", f_vs); end
      if (f_bn !== 1'b0)  begin errors++; $display("FAIL reset_blank_n got=%b exp=0", f_bn); end
      if (f_act !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", f_act); end
      if (f_ls !== 1'b0)  begin errors++; $display("FAIL reset_line_start got=%b exp=0", f_ls); end
      if (f_fs !== 1'b0)  begin errors++; $display("FAIL reset_frame_start got=%b exp=0", f_fs); end
      if (f_fc !== 8'd0)  begin errors++; $display("FAIL reset_frame_count got=%0d exp=0", f_fc); end
      if (f_sn !== 1'b0)  begin errors++; $display("FAIL reset_sync_n got=%b exp=0", f_sn); end
    end
    f_reset = 1'b0;
    s_reset = 1'b0;
    @(posedge VGA_CLK); #1;
    s_n = 1;
    checks += 2;
    if (f_x !== 10'd1) begin errors++; $display("FAIL release_x_full got=%0d exp=1", f_x); end
    if (s_x !== 10'd1) begin errors++; $display("FAIL release_x_small got=%0d exp=1", s_x); end
  endtask

  // Real timing through line 35, where the visible area begins.
  task automatic test_full_raster();
    ref_t e, p;
    bit   ehs, evs, ebn;
    int   hs_low_line0 = 0;
    for (int n = 2; n <= 28800 && errors < 40; n++) begin
      @(posedge VGA_CLK); #1;
      s_n++;
      e   = ref_full(n);
      p   = ref_full(n - 1);
      ehs = PIPE ? p.hs  : e.hs;
      evs = PIPE ? p.vs  : e.vs;
      ebn = PIPE ? p.act : e.act;
      if (n < 800 && f_hs === 1'b0) hs_low_line0++;
      checks += 9;
      if (f_x !== 10'(e.x))  begin errors++; $display("FAIL full_x n=%0d got=%0d exp=%0d", n, f_x, e.x); end
      if (f_y !== 10'(e.y))  begin errors++; $display("FAIL full_y n=%0d got=%0d exp=%0d", n, f_y, e.y); end
      if (f_hs !== ehs)      begin errors++; $display("FAIL full_hs x=%0d y=%0d got=%b exp=%b", e.x, e.y, f_hs, ehs); end
      if (f_vs !== evs)      begin errors++; $display("FAIL full_vs x=%0d y=%0d got=%b exp=%b", e.x, e.y, f_vs, evs); end
      if (f_bn !== ebn)      begin errors++; $display("FAIL full_blank_n x=%0d y=%0d got=%b exp=%b", e.x, e.y, f_bn, ebn); end
      if (f_act !== e.act)   begin errors++; $display("FAIL full_active x=%0d y=%0d got=%b exp=%b", e.x, e.y, f_act, e.act); end
      if (f_ls !== e.ls)     begin errors++; $display("FAIL full_line_start x=%0d got=%b exp=%b", e.x, f_ls, e.ls); end
      if (f_fs !== e.fs)     begin errors++; $display("FAIL full_frame_start n=%0d got=%b exp=%b", n, f_fs, e.fs); end
      if (f_fc !== 8'(e.fc)) begin errors++; $display("FAIL full_frame_count n=%0d got=%0d exp=%0d", n, f_fc, e.fc); end
    end
    // X=2..95 low in zero-skew mode; the delayed HS also stays low at X=96.
    checks++;
    if (hs_low_line0 !== (PIPE ? 95 : 94)) begin
      errors++; $display("FAIL full_hs_low_count got=%0d exp=%0d", hs_low_line0, PIPE ? 95 : 94);
    end
  endtask

  // Small raster: random reset hold, then 256+ frames with per-cycle checks.
  task automatic test_small_frames();
    ref_t e, p;
    bit   ehs, evs, ebn;
    int   act_cnt  = 0;
    int   last_fs  = 0;
    int   fs_seen  = 0;
    int   hold     = int'($urandom_range(1, 4));
    s_reset = 1'b1;
    repeat (hold) @(posedge VGA_CLK);
    #1;
    checks += 3;
    if (s_x !== 10'd0)  begin errors++; $display("FAIL small_reset_x got=%0d exp=0", s_x); end
    if (s_y !== 10'd0)  begin errors++; $display("FAIL small_reset_y got=%0d exp=0", s_y); end
    if (s_fc !== 8'd0)  begin errors++; $display("FAIL small_reset_fc got=%0d exp=0", s_fc); end
    s_reset = 1'b0;
    for (int n = 1; n <= 257 * SFR + 3 && errors < 40; n++) begin
      @(posedge VGA_CLK); #1;
      s_n = n;
      e   = ref_small(n);
      p   = ref_small(n - 1);
      ehs = PIPE ? p.hs  : e.hs;
      evs = PIPE ? p.vs  : e.vs;
      ebn = PIPE ? p.act : e.act;
      checks += 9;
      if (s_x !== 10'(e.x))  begin errors++; $display("FAIL small_x n=%0d got=%0d exp=%0d", n, s_x, e.x); end
      if (s_y !== 10'(e.y))  begin errors++; $display("FAIL small_y n=%0d got=%0d exp=%0d", n, s_y, e.y); end
      if (s_hs !== ehs)      begin errors++; $display("FAIL small_hs x=%0d y=%0d got=%b exp=%b", e.x, e.y, s_hs, ehs); end
      if (s_vs !== evs)      begin errors++; $display("FAIL small_vs x=%0d y=%0d got=%b exp=%b", e.x, e.y, s_vs, evs); end
      if (s_bn !== ebn)      begin errors++; $display("FAIL small_blank_n x=%0d y=%0d got=%b exp=%b", e.x, e.y, s_bn, ebn); end
      if (s_act !== e.act)   begin errors++; $display("FAIL small_active x=%0d y=%0d got=%b exp=%b", e.x, e.y, s_act, e.act); end
      if (s_ls !== e.ls)     begin errors++; $display("FAIL small_line_start x=%0d got=%b exp=%b", e.x, s_ls, e.ls); end
      if (s_fs !== e.fs)     begin errors++; $display("FAIL small_frame_start n=%0d got=%b exp=%b", n, s_fs, e.fs); end
      if (s_fc !== 8'(e.fc)) begin errors++; $display("FAIL small_frame_count n=%0d got=%0d exp=%0d", n, s_fc, e.fc); end
      if (n % SFR == 0) begin
        checks++;
        if (act_cnt !== SHA * SVA) begin
          errors++; $display("FAIL small_active_per_frame n=%0d got=%0d exp=%0d", n, act_cnt, SHA * SVA);
        end
        act_cnt = 0;
      end
      if (s_act === 1'b1) act_cnt++;
      if (s_fs === 1'b1) begin
        checks++;
        if (n - last_fs !== SFR) begin
          errors++; $display("FAIL small_frame_period n=%0d got=%0d exp=%0d", n, n - last_fs, SFR);
        end
        last_fs = n;
        fs_seen++;
      end
      if (n == 256 * SFR - 1) begin
        checks++;
        if (s_fc !== 8'd255) begin errors++; $display("FAIL small_fc_before_wrap got=%0d exp=255", s_fc); end
      end
      if (n == 256 * SFR) begin
        checks++;
        if (s_fc !== 8'd0) begin errors++; $display("FAIL small_fc_wrap got=%0d exp=0", s_fc); end
      end
    end
    checks++;
    if (fs_seen !== 257) begin errors++; $display("FAIL small_frame_start_count got=%0d exp=257", fs_seen); end
  endtask

  // One-cycle reset at a mid-frame point (fixed one first, then random).
  task automatic test_mid_reset();
    int tx, ty, pos, d;
    for (int it = 0; it < 5; it++) begin
      tx  = (it == 0) ? 8 : int'($urandom_range(1, SHT - 1));
      ty  = (it == 0) ? 6 : int'($urandom_range(0, 11));
      pos = s_n % SFR;
      d   = (ty * SHT + tx - pos + SFR) % SFR;
      if (d == 0) d = SFR;
      repeat (d) @(posedge VGA_CLK);
      #1;
      s_n += d;
      checks += 2;
      if (s_x !== 10'(tx)) begin errors++; $display("FAIL mid_pre_x got=%0d exp=%0d", s_x, tx); end
      if (s_y !== 10'(ty)) begin errors++; $display("FAIL mid_pre_y got=%0d exp=%0d", s_y, ty); end
      s_reset = 1'b1;
      @(posedge VGA_CLK); #1;
      s_reset = 1'b0;
      checks += 7;
      if (s_x !== 10'd0)  begin errors++; $display("FAIL mid_x got=%0d exp=0", s_x); end
      if (s_y !== 10'd0)  begin errors++; $display("FAIL mid_y got=%0d exp=0", s_y); end
      if (s_fc !== 8'd0)  begin errors++; $display("FAIL mid_frame_count got=%0d exp=0", s_fc); end
      if (s_fs !== 1'b0)  begin errors++; $display("FAIL mid_frame_start got=%b exp=0", s_fs); end
      if (s_ls !== 1'b0)  begin errors++; $display("FAIL mid_line_start got=%b exp=0", s_ls); end
      if (s_hs !== 1'b0)  begin errors++; $display("FAIL mid_hs got=%b exp=0", s_hs); end
      if (s_act !== 1'b0) begin errors++; $display("FAIL mid_active got=%b exp=0", s_act); end
      @(posedge VGA_CLK); #1;
      s_n = 1;
      checks += 2;
      if (s_x !== 10'd1) begin errors++; $display("FAIL mid_release_x got=%0d exp=1", s_x); end
      if (s_y !== 10'd0) begin errors++; $display("FAIL mid_release_y got=%0d exp=0", s_y); end
    end
  endtask

  initial begin
    f_reset = 1'b1;
    s_reset = 1'b1;
    @(negedge VGA_CLK);
    test_reset();
    test_full_raster();
    test_small_frames();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #4500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
